// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver feeding a byte FIFO; a byte is visible one cycle after the stop-bit sample.
// CSR reads answer one cycle after addr/read; a full FIFO drops incoming bytes and flags overrun.
module csr_uart_rx #(
  parameter logic [11:0] BASE_ADDR       = 12'hBC3,
  parameter int          CLK_PER_BIT     = 868,
  parameter int          FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        irq,
  input  logic        AVOID_WARNING
);

  localparam int           AW      = FIFO_DEPTH_LOG2;
  localparam int           DEPTH   = 1 << AW;
  localparam logic [15:0]  HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0]  FULL_M1 = 16'(CLK_PER_BIT - 1);
  localparam logic [AW:0]  PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  rx_state_t   state;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr, fill;
  logic        empty, full;
  logic        hit_data, hit_stat, stat_q;
  logic        overrun, irq_en;
  logic        stop_tick, push, pop, drop;
  logic        unused_bits;

  assign fill      = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign hit_data  = (addr == BASE_ADDR);
  assign hit_stat  = (addr == BASE_ADDR + 12'd1);
  assign pop       = read && hit_data && !empty;
  assign stop_tick = (state == STOP) && (cnt == '0);
  // A pop on the same edge frees a slot, so a full FIFO can still accept the byte.
  assign push      = stop_tick && rx_s2 && (!full || pop);
  assign drop      = stop_tick && !(rx_s2 && (!full || pop));
  assign irq       = irq_en && !empty;
  assign unused_bits = ^{wdata[31:3], wdata[0], AVOID_WARNING};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (state)
        IDLE: if (rx_prev && !rx_s2) begin
          cnt   <= HALF_M1;
          state <= START;
        end
        START: if (cnt != '0) cnt <= cnt - 16'd1;
          else if (!rx_s2) begin
            cnt     <= FULL_M1;
            bit_idx <= '0;
            state   <= DATA;
          end else state <= IDLE;
        DATA: if (cnt != '0) cnt <= cnt - 16'd1;
          else begin
            shreg   <= {rx_s2, shreg[7:1]};
            cnt     <= FULL_M1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        STOP: if (cnt != '0) cnt <= cnt - 16'd1;
          else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      rdata   <= '0;
      valid   <= 1'b0;
      stat_q  <= 1'b0;
      overrun <= 1'b0;
      irq_en  <= 1'b0;
    end else begin
      valid  <= hit_data || hit_stat;
      stat_q <= hit_stat;
      if (read && hit_data)
        rdata <= empty ? 32'hFFFF_FFFF : {24'b0, mem[rptr[AW-1:0]]};
      else if (read && hit_stat)
        rdata <= {16'b0, 8'(fill), 5'b0, irq_en, overrun, !empty};
      else
        rdata <= '0;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push) wptr <= wptr + PTR_ONE;
      if (stat_q) begin
        case (modify)
          3'd1: begin
            if (wdata[1]) overrun <= 1'b0;
            irq_en <= wdata[2];
          end
          3'd2: if (wdata[2]) irq_en <= 1'b1;
          3'd3: begin
            if (wdata[1]) overrun <= 1'b0;
            if (wdata[2]) irq_en <= 1'b0;
          end
          default: ;
        endcase
      end
      // A receive error on the same edge as a software clear must not be lost.
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/csr_uart_rx.md
Name: csr_uart_rx

Overview:
- CSR-mapped UART receiver: deserialises an 8N1 serial line into a byte FIFO.
- Software pops received bytes through CSR reads.
- The CSR-bus counterpart to the transmit-side UART CSR write path: characters flow from the serial pin into the pipeline.
- Sits on the shared OR-combined CSR response bus alongside the ID, counter, pin and timer responders.

Parameters:
- BASE_ADDR, 12'hBC3: data CSR address. Status CSR is at BASE_ADDR+1.
- CLK_PER_BIT, 868: clock cycles per bit (e.g. 100 MHz / 115200). Legal range 4..65535.
- FIFO_DEPTH_LOG2, 3: log2 of FIFO depth (default depth 8).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous reset, active low
- read  input  1  CSR read strobe, qualified by addr in the same cycle
- modify  input  3  CSR modify op: 0 none, 1 write, 2 set, 3 clear. Applies to the address registered in the previous cycle.
- wdata  input  32  CSR write data
- addr  input  12  CSR address
- rdata  output  32  read data; zero unless this block responds
- valid  output  1  this block owns addr (registered)
- rx  input  1  serial input, idle high, asynchronous to clk
- irq  output  1  FIFO non-empty AND irq enable
- AVOID_WARNING  input  1  unused; leave unconnected

Behaviour:
- Reset values: rdata=0, valid=0, irq=0, FIFO empty, overrun=0, irq_en=0, receiver in IDLE, synchroniser=2'b11.
- CSR timing:
  - Cycle N: addr and read sampled.
  - Cycle N+1: valid=1 iff addr in {BASE_ADDR, BASE_ADDR+1}. rdata is registered; it is 0 whenever valid=0.
  - modify in cycle N+1 acts on the cycle-N address.
- Data CSR read:
  - FIFO non-empty: rdata={24'b0, head byte}; pop on the same edge.
  - FIFO empty: rdata=32'hFFFF_FFFF; no pop.
  - No pop without read=1 (a CSR write alone does not pop).
  - Writes to the data CSR are ignored.
- Status CSR:
  - Layout: [31:16] zero, [15:8] fill count, [2] irq_en, [1] overrun, [0] non-empty.
  - Write: bit1=1 clears overrun; irq_en=bit2.
  - Set: bit2 sets irq_en.
  - Clear: bit1 clears overrun; bit2 clears irq_en.
- rx path:
  - Two-flop synchroniser; the FSM uses only the synchronised bit.
- Receiver FSM (IDLE, START, DATA, STOP):
  - IDLE: falling edge (1→0) loads counter=CLK_PER_BIT/2-1 → START.
  - START: at counter=0, sample. Low → counter=CLK_PER_BIT-1, bit index 0 → DATA. High (glitch) → IDLE.
  - DATA: at counter=0, shift in LSB first, reload counter. After bit 7 → STOP.
  - STOP: at counter=0, sample.
    - High: push byte if FIFO not full, else set overrun and drop the byte.
    - Low (framing error): discard the byte, set overrun.
    - Both cases → IDLE.
- Latency: byte visible (non-empty=1) the cycle after the STOP-midpoint sample edge.
- FIFO:
  - Circular buffer; read/write pointers of FIFO_DEPTH_LOG2+1 bits, wrap naturally.
  - Full when pointers differ only in the MSB; count = wptr - rptr.
  - Simultaneous push and pop on a full FIFO: pop takes effect first, push succeeds, count unchanged, overrun not set.
  - Simultaneous push and pop on an empty FIFO: read returns FFFF_FFFF, the byte is pushed, count becomes 1.
- Reset mid-frame: immediate async return to the reset state; the partial byte and the FIFO contents are lost.
- rx held low indefinitely (break):
  - One framing error results.
  - The FSM then waits in IDLE until it sees a 1→0 edge.

Test Plan:
- CLK_PER_BIT=8: send 0x55 then 0xA3. Two data reads return 0x00000055, then 0x000000A3. A third read returns 0xFFFFFFFF.
- Send 10 bytes 0x00..0x09 with no reads (depth 8). Status reads count=8, overrun=1, non-empty=1. Reads return 0x00..0x07. A clear with wdata=2 makes status bit1=0.
- Send 0x41 with the stop bit forced low. FIFO stays empty, overrun=1. A following valid 0x42 reads back 0x42.
- A 2-cycle low glitch on rx while idle pushes no byte. Status reads 0x00000000.
- Set irq_en (modify=2, wdata=4), then receive 0x7E. irq rises the cycle after the stop sample and falls the cycle after the popping read.
- Non-matching address (0xBC2) read gives valid=0, rdata=0. Asserting rstn=0 mid-DATA gives FIFO empty, rdata=0, and the next full frame is received correctly.
